// File: rtl/spi_slave_sync_if.sv
// SPI pin and register-bank handshake bundle for spi_slave_sync.
// master: MCU/bench side driving the pins and readback word; slave: the front end.
interface spi_slave_sync_if #(
    parameter int unsigned WIDTH = 16
);
    logic             spi_clk;
    logic             spi_cs;
    logic             spi_special;
    logic             spi_mosi;
    logic             spi_miso;
    logic [WIDTH-1:0] tx_word;
    logic             tx_ack;
    logic [WIDTH-1:0] rx_word;
    logic             rx_valid;
    logic             frame_err;
    logic             busy;

    modport master (
        output spi_clk, spi_cs, spi_special, spi_mosi, tx_word,
        input  spi_miso, tx_ack, rx_word, rx_valid, frame_err, busy
    );

    modport slave (
        input  spi_clk, spi_cs, spi_special, spi_mosi, tx_word,
        output spi_miso, tx_ack, rx_word, rx_valid, frame_err, busy
    );
endinterface

// File: rtl/spi_slave_sync.sv
// Oversampling SPI slave front end: frames are decoded entirely in the clk domain.
// Optional SPI_SLAVE_SYNC_ECHO_EN: frame start loads the last valid rx_word for MISO loopback.
module spi_slave_sync #(
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             rst_n,
    spi_slave_sync_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Asynchronous assertion, synchronised release
    logic [1:0] rst_sync;
    logic       rst_i_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= '0;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i_n = rst_sync[1];

    logic [SYNC_STAGES-1:0] sck_s, mosi_s, cs_s, spc_s;
    logic                   sck_h, cs_h;
    logic [SYNC_STAGES:0]   settle;
    logic                   armed;

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            sck_s  <= '0;
            mosi_s <= '0;
            cs_s   <= '1;
            spc_s  <= '1;
            sck_h  <= 1'b0;
            cs_h   <= 1'b1;
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            sck_s  <= {sck_s[SYNC_STAGES-2:0], bus.spi_clk};
            mosi_s <= {mosi_s[SYNC_STAGES-2:0], bus.spi_mosi};
            cs_s   <= {cs_s[SYNC_STAGES-2:0], bus.spi_cs};
            spc_s  <= {spc_s[SYNC_STAGES-2:0], bus.spi_special};
            sck_h  <= sck_s[SYNC_STAGES-1];
            cs_h   <= cs_s[SYNC_STAGES-1];
            settle <= {settle[SYNC_STAGES-1:0], 1'b1};
            // A frame already in progress at reset release must not look like a fresh cs_fall
            armed  <= armed | (settle[SYNC_STAGES] & cs_s[SYNC_STAGES-1]);
        end
    end

    logic sck_sync, mosi_sync, cs_sync, spc_sync;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    assign sck_sync  = sck_s[SYNC_STAGES-1];
    assign mosi_sync = mosi_s[SYNC_STAGES-1];
    assign cs_sync   = cs_s[SYNC_STAGES-1];
    assign spc_sync  = spc_s[SYNC_STAGES-1];
    assign sck_rise  = sck_sync & ~sck_h;
    assign sck_fall  = ~sck_sync & sck_h;
    assign cs_rise   = cs_sync & ~cs_h;
    assign cs_fall   = ~cs_sync & cs_h & armed;

    state_t state, state_nxt;

    logic [CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [WIDTH-1:0] rx_shift, rx_shift_nxt;
    logic [WIDTH-2:0] tx_shift, tx_shift_nxt;
    logic [WIDTH-1:0] rx_word_q, rx_word_nxt;
    logic [WIDTH-1:0] load_word;
    logic             miso_q, miso_nxt;
    logic             tx_ack_q, tx_ack_nxt;
    logic             rx_valid_q, rx_valid_nxt;
    logic             frame_err_q, frame_err_nxt;
    logic             busy_q;

`ifdef SPI_SLAVE_SYNC_ECHO_EN
    assign load_word = rx_word_q;
`else
    assign load_word = bus.tx_word;
`endif

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Priority in SHIFT: special abort, then cs_rise, then sck edges
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cs_fall && !spc_sync) state_nxt = SHIFT;
            SHIFT: begin
                if (spc_sync)     state_nxt = IDLE;
                else if (cs_rise) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // miso_q is the MSB of the logical tx shift register; tx_shift holds the bits still to send
    always_comb begin
        bit_cnt_nxt   = bit_cnt;
        rx_shift_nxt  = rx_shift;
        tx_shift_nxt  = tx_shift;
        rx_word_nxt   = rx_word_q;
        miso_nxt      = 1'b0;
        tx_ack_nxt    = 1'b0;
        rx_valid_nxt  = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (cs_fall && !spc_sync) begin
                    bit_cnt_nxt  = '0;
                    rx_shift_nxt = '0;
                    tx_shift_nxt = load_word[WIDTH-2:0];
                    miso_nxt     = load_word[WIDTH-1];
                    tx_ack_nxt   = 1'b1;
                end
            end
            SHIFT: begin
                miso_nxt = miso_q;
                if (spc_sync) begin
                    frame_err_nxt = 1'b1;
                    miso_nxt      = 1'b0;
                end else if (cs_rise) begin
                    miso_nxt = 1'b0;
                end else begin
                    if (sck_fall) begin
                        rx_shift_nxt = {rx_shift[WIDTH-2:0], mosi_sync};
                        if (bit_cnt != CNT_W'(WIDTH + 1)) bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    end
                    // The leading rise re-launches the MSB already on the pin; later rises advance
                    if (sck_rise && bit_cnt != '0) begin
                        miso_nxt     = tx_shift[WIDTH-2];
                        tx_shift_nxt = {tx_shift[WIDTH-3:0], 1'b0};
                    end
                end
            end
            DONE: begin
                if (bit_cnt == CNT_W'(WIDTH)) begin
                    rx_word_nxt  = rx_shift;
                    rx_valid_nxt = 1'b1;
                end else begin
                    frame_err_nxt = 1'b1;
                end
            end
            default: miso_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_i_n) begin
        if (!rst_i_n) begin
            bit_cnt     <= '0;
            rx_shift    <= '0;
            tx_shift    <= '0;
            rx_word_q   <= '0;
            miso_q      <= 1'b0;
            tx_ack_q    <= 1'b0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            bit_cnt     <= bit_cnt_nxt;
            rx_shift    <= rx_shift_nxt;
            tx_shift    <= tx_shift_nxt;
            rx_word_q   <= rx_word_nxt;
            miso_q      <= miso_nxt;
            tx_ack_q    <= tx_ack_nxt;
            rx_valid_q  <= rx_valid_nxt;
            frame_err_q <= frame_err_nxt;
            busy_q      <= (state_nxt == SHIFT);
        end
    end

    assign bus.spi_miso  = miso_q;
    assign bus.tx_ack    = tx_ack_q;
    assign bus.rx_word   = rx_word_q;
    assign bus.rx_valid  = rx_valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
endmodule

// File: doc/spi_slave_sync.md
Name: spi_slave_sync

Overview:
- Upstream front end for the register bank. Oversamples the MCU SPI pins (CLK, CS, SPECIAL, MOSI) in the fabric clock domain.
- Deserialises complete 16-bit "special" frames into a word plus a one-cycle valid strobe.
- Serialises a readback word onto MISO during the same frame.
- Moves SPI decode out of the SPI-clock and CS-edge domains, so downstream register logic becomes fully synchronous to clk.

Parameters:
- WIDTH, 16, frame length in bits. Legal range 8..32.
- SYNC_STAGES, 2, synchroniser flops per input pin before edge detection. Legal range 2..3.

Ports:
- clk  in  1  fabric clock (XTALCLK). Must be at least 4x the spi_clk frequency.
- rst_n  in  1  asynchronous active-low reset; release is synchronised to clk.
- spi_clk  in  1  SPI SCK from MCU, idle low.
- spi_cs  in  1  SPI chip select, active low.
- spi_special  in  1  register-bank select, active low.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first.
- tx_word  in  WIDTH  readback word, sampled at frame start.
- tx_ack  out  1  one-cycle pulse: tx_word has been captured.
- rx_word  out  WIDTH  last complete frame; held until the next valid frame.
- rx_valid  out  1  one-cycle pulse: rx_word has just been updated.
- frame_err  out  1  one-cycle pulse: frame aborted or bit count wrong.
- busy  out  1  high while in the SHIFT state.

Behaviour:
- Synchronisation
  - All four SPI inputs pass through SYNC_STAGES flops, plus one history flop for edge detection.
  - Sck_fall, sck_rise, cs_fall and cs_rise are each single-cycle pulses derived from the synchronised signals.
- Reset values (all outputs)
  - rx_word=0, rx_valid=0, tx_ack=0, frame_err=0, busy=0, spi_miso=0.
  - State=IDLE, bit_cnt=0.
  - Synchroniser flops reset to 1 for cs/special and to 0 for clk/mosi.
- FSM states: IDLE, SHIFT, DONE.
- IDLE
  - On cs_fall with synchronised special=0: go to SHIFT, clear bit_cnt, load tx_shift<=tx_word, pulse tx_ack.
  - Spi_miso is driven with tx_word[WIDTH-1] on the same cycle.
  - cs_fall with special=1 is ignored; the frame belongs to a muxed peripheral.
- SHIFT
  - On sck_fall: rx_shift<={rx_shift[WIDTH-2:0], mosi_sync}; bit_cnt increments, saturating at WIDTH+1.
  - On sck_rise: tx_shift shifts left with zero fill; spi_miso<=new MSB.
  - Spi_miso only changes on sck_rise or at frame start.
- Leaving SHIFT
  - On cs_rise: go to DONE.
  - If synchronised special rises while in SHIFT: abort immediately, pulse frame_err, go to IDLE.
  - After an abort, rx_word is unchanged.
- DONE (exactly 1 cycle, then IDLE)
  - If bit_cnt==WIDTH: rx_word<=rx_shift and rx_valid=1.
  - Otherwise (including 0 bits, or more than WIDTH bits): frame_err=1 and rx_word is unchanged.
- Spi_miso is 0 whenever the state is not SHIFT; external muxing selects it.
- Latency
  - rx_valid is asserted SYNC_STAGES+2 clk cycles after the physical CS rising edge.
  - tx_ack is asserted SYNC_STAGES+1 cycles after the physical CS falling edge.
- Simultaneous-event priority within one cycle: special-abort, then cs_rise, then sck edges.
  - An sck_fall coinciding with cs_rise is not counted.
- Reset mid-frame
  - All state clears immediately and no strobe is emitted.
  - The remainder of that frame is ignored until the next cs_fall.

Optional Feature:
- Macro: SPI_SLAVE_SYNC_ECHO_EN.
- Defined: at frame start, tx_shift loads the current rx_word (the last valid frame) instead of tx_word. tx_ack still pulses. This gives an MCU link loopback test.
- Undefined: tx_word is loaded as described in Behaviour.

Test Plan:
- clk=12 MHz, spi_clk=1 MHz, special=0. Send 0x07A5. Required: rx_word=0x07A5, one rx_valid pulse, frame_err never asserts, tx_ack pulses once.
- tx_word=0xFF00 with a 16-bit frame. Required: the MISO bits captured on SCK falling edges read 0xFF00 MSB first, and MISO=0 after CS deasserts.
- Short frame of 12 clocks, then a long frame of 17 clocks. Required: frame_err pulses once per frame, no rx_valid, and rx_word retains its previous value 0x07A5.
- special=1 with CS toggled over a 16-clock frame. Required: no tx_ack, no rx_valid, no frame_err, MISO stays 0.
- special deasserted after 8 bits. Required: frame_err pulse, busy drops within SYNC_STAGES+2 cycles, rx_word unchanged. The next valid frame 0x0B00 is received correctly.
- rst_n asserted at bit 10 of a frame. Required: all outputs are 0 immediately, no strobe for that frame, and the following frame 0x0E01 yields rx_valid. With ECHO_EN, the frame after that returns 0x0E01 on MISO.
